sysid_checker: RTL and testbench
================================

Name: sysid_checker

Overview:
- Avalon-MM master controller that sequences reads of the system ID peripheral: word 0 (system ID) at address 0, then word 1 (build timestamp) at address 1.
- Compares both words against build-time expected values and publishes sticky pass/fail/timeout status.
- Sits between the reset/boot sequencer (start) and the sysid control slave. Gates peripheral bring-up until the hardware/software build match is confirmed.
- Optional periodic re-check.

Parameters:
- EXPECTED_ID, 32'h00000000: expected word at address 0.
- EXPECTED_TIMESTAMP, 32'd1523017966: expected word at address 1.
- TIMEOUT_CYCLES, 255: maximum cycles per read transaction, counted from issue to readdatavalid. Range 1..65535.
- RECHECK_PERIOD, 0: cycles spent in DONE before an automatic restart. 0 disables re-check. Counter is 32-bit.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run a check; ignored while busy.
- master_address  out  1  sysid word select.
- master_read  out  1  Avalon read request.
- master_waitrequest  in  1  slave stall.
- master_readdata  in  32  read data.
- master_readdatavalid  in  1  read data qualifier.
- busy  out  1  high from acceptance of start until entry to DONE.
- done  out  1  one-cycle pulse on entry to DONE.
- id_ok  out  1  sticky: captured ID == EXPECTED_ID.
- timestamp_ok  out  1  sticky: captured timestamp == EXPECTED_TIMESTAMP.
- timeout_err  out  1  sticky: a transaction exceeded TIMEOUT_CYCLES.
- read_id  out  32  captured word 0.
- read_timestamp  out  32  captured word 1.

Behaviour:
- Reset: state=IDLE.
  - All outputs 0: master_read, master_address, busy, done, id_ok, timestamp_ok, timeout_err, read_id, read_timestamp.
  - Timeout and recheck counters are cleared.
  - Reset mid-transaction drops master_read in the cycle after reset is sampled. Outstanding data arriving later is ignored (the FSM is in IDLE).
- IDLE:
  - start=1 moves to RD_ID_REQ.
  - On entry to RD_ID_REQ: busy=1; id_ok, timestamp_ok, timeout_err, read_id, read_timestamp cleared; timeout counter=0.
- RD_ID_REQ:
  - Drives master_read=1, master_address=0.
  - Holds address and read stable while master_waitrequest=1.
  - On a cycle with master_read=1 and waitrequest=0, the read is accepted. Next state is RD_ID_WAIT and master_read=0 in the next cycle.
- RD_ID_WAIT:
  - master_readdatavalid=1 captures read_id<=master_readdata, then goes to RD_TS_REQ with the timeout counter cleared.
  - readdatavalid is never sampled in the acceptance cycle itself. Minimum acceptance-to-data latency is 1 cycle.
- RD_TS_REQ / RD_TS_WAIT:
  - Identical to the ID read, with master_address=1.
  - Captured data goes to read_timestamp, then the FSM moves to COMPARE.
- COMPARE (1 cycle):
  - id_ok <= (read_id==EXPECTED_ID); timestamp_ok <= (read_timestamp==EXPECTED_TIMESTAMP).
  - Then DONE.
- Timeout:
  - The counter increments every cycle in any REQ/WAIT state.
  - When it equals TIMEOUT_CYCLES-1 without completion: master_read=0 next cycle, timeout_err=1, id_ok=timestamp_ok=0, then go to DONE.
- DONE:
  - Entry cycle: done=1 for exactly one cycle; busy=0.
  - Status outputs and read_* hold until the next start.
  - start=1 in DONE restarts exactly as from IDLE.
  - If RECHECK_PERIOD>0, the recheck counter counts cycles in DONE. At RECHECK_PERIOD it auto-restarts as if start were pulsed.
  - A start coincident with expiry restarts once.
- Start handling: start while busy is ignored, not queued.
- Stray data: readdatavalid outside a WAIT state is ignored and alters nothing.
- Total latency:
  - With zero-wait slave and 1-cycle data latency: start to done pulse = 6 cycles.
  - Sequence: REQ0, WAIT0, REQ1, WAIT1, COMPARE, DONE entry.
- Protocol rule: only one outstanding read at any time; master_read is never asserted in WAIT states.

Test Plan:
- Matching slave (addr0→0x00000000, addr1→1523017966), waitrequest=0, 1-cycle latency, start pulse → done at cycle 6; id_ok=1, timestamp_ok=1, timeout_err=0, read_timestamp=1523017966.
- Slave returns 0x12345678 at addr0 → id_ok=0, timestamp_ok=1, read_id=0x12345678; done pulses once.
- waitrequest held 3 cycles on each read, data latency 2 → master_address/read stable during stall, one accepted read per word, done at cycle 14, both ok=1.
- TIMEOUT_CYCLES=8, readdatavalid never asserted → master_read drops, timeout_err=1 with done 8 cycles after the ID read issue, id_ok=timestamp_ok=0; late readdatavalid afterwards changes nothing.
- start re-pulsed while busy, then reset asserted during RD_TS_WAIT → second start ignored; after reset all outputs 0, and a subsequent start completes normally.
- RECHECK_PERIOD=20, slave timestamp changed after first pass → automatic second check 20 cycles after DONE entry, timestamp_ok transitions 1→0, done pulses twice total.

Source files
------------

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the two sysid words, compares them with build-time
// constants and publishes sticky pass/fail/timeout status, with optional re-check.
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1523017966,
   parameter int          TIMEOUT_CYCLES     = 255,
   parameter int          RECHECK_PERIOD     = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        master_address,
   output logic        master_read,
   input  logic        master_waitrequest,
   input  logic [31:0] master_readdata,
   input  logic        master_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        timestamp_ok,
   output logic        timeout_err,
   output logic [31:0] read_id,
   output logic [31:0] read_timestamp
);

   typedef enum logic [2:0] {
      IDLE, RD_ID_REQ, RD_ID_WAIT, RD_TS_REQ, RD_TS_WAIT, COMPARE, DONE
   } state_t;

   localparam logic [15:0] TMO_LAST     = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] RECHECK_LAST = 32'(RECHECK_PERIOD - 1);

   state_t      state, state_next;
   logic [15:0] tmo_cnt;
   logic [31:0] recheck_cnt;
   logic        in_xfer, tmo_hit, recheck_hit, launch, tmo_clr;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next     = state;
      master_read    = 1'b0;
      master_address = 1'b0;
      in_xfer        = (state == RD_ID_REQ) || (state == RD_ID_WAIT) ||
                       (state == RD_TS_REQ) || (state == RD_TS_WAIT);
      tmo_hit        = in_xfer && (tmo_cnt == TMO_LAST);
      recheck_hit    = (RECHECK_PERIOD > 0) && (state == DONE) &&
                       (recheck_cnt == RECHECK_LAST);
      busy           = in_xfer || (state == COMPARE);
      // A request that is accepted on the last allowed cycle still times out;
      // only returned data counts as completion.
      case (state)
         IDLE:       if (start) state_next = RD_ID_REQ;
         RD_ID_REQ: begin
            master_read = 1'b1;
            if (tmo_hit)                  state_next = DONE;
            else if (!master_waitrequest) state_next = RD_ID_WAIT;
         end
         RD_ID_WAIT: begin
            if (master_readdatavalid) state_next = RD_TS_REQ;
            else if (tmo_hit)         state_next = DONE;
         end
         RD_TS_REQ: begin
            master_read    = 1'b1;
            master_address = 1'b1;
            if (tmo_hit)                  state_next = DONE;
            else if (!master_waitrequest) state_next = RD_TS_WAIT;
         end
         RD_TS_WAIT: begin
            if (master_readdatavalid) state_next = COMPARE;
            else if (tmo_hit)         state_next = DONE;
         end
         COMPARE:    state_next = DONE;
         DONE:       if (start || recheck_hit) state_next = RD_ID_REQ;
         default:    state_next = IDLE;
      endcase
      launch  = (state_next == RD_ID_REQ) && ((state == IDLE) || (state == DONE));
      tmo_clr = launch || ((state == RD_ID_WAIT) && (state_next == RD_TS_REQ));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         done           <= 1'b0;
         id_ok          <= 1'b0;
         timestamp_ok   <= 1'b0;
         timeout_err    <= 1'b0;
         read_id        <= 32'h0;
         read_timestamp <= 32'h0;
         tmo_cnt        <= 16'h0;
         recheck_cnt    <= 32'h0;
      end else begin
         done <= (state_next == DONE) && (state != DONE);

         if (tmo_clr)      tmo_cnt <= 16'h0;
         else if (in_xfer) tmo_cnt <= tmo_cnt + 16'd1;

         // Counts cycles spent in DONE; zero on the entry cycle.
         if ((state == DONE) && (state_next == DONE)) recheck_cnt <= recheck_cnt + 32'd1;
         else                                         recheck_cnt <= 32'h0;

         if (launch) begin
            id_ok          <= 1'b0;
            timestamp_ok   <= 1'b0;
            timeout_err    <= 1'b0;
            read_id        <= 32'h0;
            read_timestamp <= 32'h0;
         end

         if ((state == RD_ID_WAIT) && master_readdatavalid) read_id        <= master_readdata;
         if ((state == RD_TS_WAIT) && master_readdatavalid) read_timestamp <= master_readdata;

         if (state == COMPARE) begin
            id_ok        <= (read_id == EXPECTED_ID);
            timestamp_ok <= (read_timestamp == EXPECTED_TIMESTAMP);
         end

         if (in_xfer && (state_next == DONE)) begin
            timeout_err  <= 1'b1;
            id_ok        <= 1'b0;
            timestamp_ok <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: instance a (timeout 8) covers read, stall,
// timeout and reset scenarios; instance b (re-check period 20) covers auto re-check.
module tb_sysid_checker;

   localparam logic [31:0] TS = 32'd1523017966;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // ---------------- instance a ----------------
   logic        a_start = 1'b0;
   logic        a_address, a_read, a_wr, a_rdv;
   logic [31:0] a_rdata;
   logic        a_busy, a_done, a_id_ok, a_ts_ok, a_tmo;
   logic [31:0] a_read_id, a_read_ts;

   int          a_wait = 0;
   int          a_lat = 1;
   bit          a_respond = 1'b1;
   logic [31:0] a_d0 = 32'h0;
   logic [31:0] a_d1 = TS;
   logic        a_stray = 1'b0;
   logic [31:0] a_stray_data = 32'h0;
   int          a_stall = 0;
   bit          a_pend = 1'b0;
   int          a_cd = 0;
   logic        a_pend_addr = 1'b0;
   logic        a_slave_rdv = 1'b0;
   logic [31:0] a_slave_data = 32'h0;

   assign a_wr    = a_read && (a_stall < a_wait);
   assign a_rdv   = a_slave_rdv | a_stray;
   assign a_rdata = a_stray ? a_stray_data : a_slave_data;

   // Slave model: stalls each request a_wait cycles, returns data a_lat cycles after acceptance.
   always @(posedge clock) begin
      a_slave_rdv <= 1'b0;
      if (a_pend) begin
         if (a_cd <= 1) begin
            a_pend       <= 1'b0;
            a_slave_rdv  <= a_respond;
            a_slave_data <= a_pend_addr ? a_d1 : a_d0;
         end else begin
            a_cd <= a_cd - 1;
         end
      end
      if (a_read && !a_wr) begin
         a_stall <= 0;
         if (a_lat <= 1) begin
            a_slave_rdv  <= a_respond;
            a_slave_data <= a_address ? a_d1 : a_d0;
         end else begin
            a_pend      <= 1'b1;
            a_cd        <= a_lat - 1;
            a_pend_addr <= a_address;
         end
      end else if (a_read) begin
         a_stall <= a_stall + 1;
      end
   end

   sysid_checker #(.TIMEOUT_CYCLES(8), .RECHECK_PERIOD(0)) dut_a (
      .clock(clock), .reset(reset), .start(a_start),
      .master_address(a_address), .master_read(a_read),
      .master_waitrequest(a_wr), .master_readdata(a_rdata),
      .master_readdatavalid(a_rdv),
      .busy(a_busy), .done(a_done), .id_ok(a_id_ok), .timestamp_ok(a_ts_ok),
      .timeout_err(a_tmo), .read_id(a_read_id), .read_timestamp(a_read_ts)
   );

   // ---------------- instance b ----------------
   logic        b_start = 1'b0;
   logic        b_address, b_read;
   logic        b_wr = 1'b0;
   logic        b_rdv = 1'b0;
   logic [31:0] b_rdata = 32'h0;
   logic [31:0] b_d1 = TS;
   logic        b_busy, b_done, b_id_ok, b_ts_ok, b_tmo;
   logic [31:0] b_read_id, b_read_ts;

   always @(posedge clock) begin
      b_rdv <= 1'b0;
      if (b_read) begin
         b_rdv   <= 1'b1;
         b_rdata <= b_address ? b_d1 : 32'h0;
      end
   end

   sysid_checker #(.RECHECK_PERIOD(20)) dut_b (
      .clock(clock), .reset(reset), .start(b_start),
      .master_address(b_address), .master_read(b_read),
      .master_waitrequest(b_wr), .master_readdata(b_rdata),
      .master_readdatavalid(b_rdv),
      .busy(b_busy), .done(b_done), .id_ok(b_id_ok), .timestamp_ok(b_ts_ok),
      .timeout_err(b_tmo), .read_id(b_read_id), .read_timestamp(b_read_ts)
   );

   // ---------------- driver tasks ----------------
   task automatic pulse_a_start;
      a_start = 1'b1;
      @(negedge clock);
      a_start = 1'b0;
   endtask

   task automatic wait_a_done(input int limit, output int cyc);
      cyc = 1;
      while (!a_done && cyc < limit) begin
         @(negedge clock);
         cyc++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      checks++;
      if ({a_read, a_address, a_busy, a_done, a_id_ok, a_ts_ok, a_tmo} !== 7'b0) begin
         errors++;
         $display("FAIL reset_a_flags: got %b, want 0000000",
                  {a_read, a_address, a_busy, a_done, a_id_ok, a_ts_ok, a_tmo});
      end
      checks++;
      if ({a_read_id, a_read_ts} !== 64'h0) begin
         errors++;
         $display("FAIL reset_a_data: got %h %h, want 0 0", a_read_id, a_read_ts);
      end
      checks++;
      if ({b_read, b_address, b_busy, b_done, b_id_ok, b_ts_ok, b_tmo, b_read_id, b_read_ts} !== 71'h0) begin
         errors++;
         $display("FAIL reset_b_outputs: got nonzero (read_id=%h read_ts=%h), want all 0",
                  b_read_id, b_read_ts);
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_match;
      int cyc;
      a_d0 = 32'h0; a_d1 = TS; a_wait = 0; a_lat = 1; a_respond = 1'b1;
      pulse_a_start();
      checks++;
      if ({a_busy, a_read, a_address} !== 3'b110) begin
         errors++;
         $display("FAIL match_first_req: busy/read/addr got %b, want 110", {a_busy, a_read, a_address});
      end
      wait_a_done(40, cyc);
      checks++;
      if (cyc !== 6 || a_done !== 1'b1) begin
         errors++;
         $display("FAIL match_latency: done at cycle %0d (done=%b), want 6", cyc, a_done);
      end
      checks++;
      if ({a_id_ok, a_ts_ok, a_tmo, a_busy} !== 4'b1100) begin
         errors++;
         $display("FAIL match_status: id_ok/ts_ok/tmo/busy got %b, want 1100",
                  {a_id_ok, a_ts_ok, a_tmo, a_busy});
      end
      checks++;
      if (a_read_ts !== TS || a_read_id !== 32'h0) begin
         errors++;
         $display("FAIL match_data: got id=%h ts=%0d, want id=0 ts=%0d", a_read_id, a_read_ts, TS);
      end
      @(negedge clock);
      checks++;
      if (a_done !== 1'b0 || a_id_ok !== 1'b1) begin
         errors++;
         $display("FAIL match_done_pulse: done=%b id_ok=%b, want done=0 id_ok=1", a_done, a_id_ok);
      end
   endtask

   task automatic test_id_mismatch;
      int pulses = 0;
      a_d0 = 32'h1234_5678;
      pulse_a_start();
      for (int i = 0; i < 14; i++) begin
         if (a_done) pulses++;
         @(negedge clock);
      end
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("FAIL mismatch_done_count: got %0d pulses, want 1", pulses);
      end
      checks++;
      if ({a_id_ok, a_ts_ok, a_tmo} !== 3'b010) begin
         errors++;
         $display("FAIL mismatch_status: id_ok/ts_ok/tmo got %b, want 010", {a_id_ok, a_ts_ok, a_tmo});
      end
      checks++;
      if (a_read_id !== 32'h1234_5678) begin
         errors++;
         $display("FAIL mismatch_read_id: got %h, want 12345678", a_read_id);
      end
      a_d0 = 32'h0;
   endtask

   task automatic test_stall;
      int cyc, done_cyc = 0, acc0 = 0, acc1 = 0, unstable = 0;
      logic prev_stall = 1'b0, prev_addr = 1'b0;
      a_wait = 3; a_lat = 2;
      pulse_a_start();
      for (cyc = 1; cyc <= 24; cyc++) begin
         if (prev_stall && !(a_read && a_address == prev_addr)) unstable++;
         if (a_read && !a_wr) begin
            if (a_address) acc1++;
            else           acc0++;
         end
         if (a_done && done_cyc == 0) done_cyc = cyc;
         prev_stall = a_read && a_wr;
         prev_addr  = a_address;
         @(negedge clock);
      end
      checks++;
      if (unstable !== 0) begin
         errors++;
         $display("FAIL stall_stable: %0d unstable request cycles, want 0", unstable);
      end
      checks++;
      if (acc0 !== 1 || acc1 !== 1) begin
         errors++;
         $display("FAIL stall_accepts: addr0=%0d addr1=%0d, want 1 1", acc0, acc1);
      end
      checks++;
      if (done_cyc !== 14) begin
         errors++;
         $display("FAIL stall_latency: done at cycle %0d, want 14", done_cyc);
      end
      checks++;
      if ({a_id_ok, a_ts_ok, a_tmo} !== 3'b110) begin
         errors++;
         $display("FAIL stall_status: id_ok/ts_ok/tmo got %b, want 110", {a_id_ok, a_ts_ok, a_tmo});
      end
      a_wait = 0; a_lat = 1;
   endtask

   task automatic test_timeout;
      int cyc;
      a_respond = 1'b0;
      pulse_a_start();
      wait_a_done(40, cyc);
      checks++;
      if (cyc !== 9 || a_done !== 1'b1) begin
         errors++;
         $display("FAIL timeout_latency: done at cycle %0d (done=%b), want 9", cyc, a_done);
      end
      checks++;
      if ({a_read, a_tmo, a_id_ok, a_ts_ok, a_busy} !== 5'b01000) begin
         errors++;
         $display("FAIL timeout_status: read/tmo/id_ok/ts_ok/busy got %b, want 01000",
                  {a_read, a_tmo, a_id_ok, a_ts_ok, a_busy});
      end
      @(negedge clock);
      a_stray_data = 32'hDEAD_BEEF;
      a_stray      = 1'b1;
      @(negedge clock);
      a_stray = 1'b0;
      @(negedge clock);
      checks++;
      if ({a_tmo, a_id_ok, a_ts_ok, a_busy, a_done, a_read} !== 6'b100000 ||
          a_read_id !== 32'h0 || a_read_ts !== 32'h0) begin
         errors++;
         $display("FAIL timeout_stray: flags %b id=%h ts=%h, want 100000 0 0",
                  {a_tmo, a_id_ok, a_ts_ok, a_busy, a_done, a_read}, a_read_id, a_read_ts);
      end
      a_respond = 1'b1;
   endtask

   task automatic test_busy_reset;
      int cyc, pulses = 0;
      a_lat = 3;
      pulse_a_start();
      @(negedge clock);
      pulse_a_start();
      repeat (2) @(negedge clock);
      checks++;
      if ({a_read, a_address, a_busy} !== 3'b111) begin
         errors++;
         $display("FAIL busy_start_ignored: cycle 5 read/addr/busy got %b, want 111",
                  {a_read, a_address, a_busy});
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checks++;
      if ({a_read, a_address, a_busy, a_done, a_id_ok, a_ts_ok, a_tmo} !== 7'b0 || a_read_id !== 32'h0) begin
         errors++;
         $display("FAIL reset_midflight: flags %b id=%h, want 0000000 0",
                  {a_read, a_address, a_busy, a_done, a_id_ok, a_ts_ok, a_tmo}, a_read_id);
      end
      for (int i = 0; i < 5; i++) begin
         if (a_done || a_busy || a_read) pulses++;
         @(negedge clock);
      end
      checks++;
      if (pulses !== 0 || a_read_ts !== 32'h0 || a_ts_ok !== 1'b0) begin
         errors++;
         $display("FAIL reset_late_data: activity=%0d ts=%h ts_ok=%b, want 0 0 0", pulses, a_read_ts, a_ts_ok);
      end
      a_lat = 1;
      pulse_a_start();
      wait_a_done(40, cyc);
      checks++;
      if (cyc !== 6 || {a_id_ok, a_ts_ok, a_tmo} !== 3'b110) begin
         errors++;
         $display("FAIL reset_rerun: done at cycle %0d status %b, want 6 110", cyc, {a_id_ok, a_ts_ok, a_tmo});
      end
   endtask

   task automatic test_recheck;
      int pulses = 0, first_cyc = 0, second_cyc = 0;
      logic ts1 = 1'bx, ts2 = 1'bx, busy25 = 1'bx, busy26 = 1'bx;
      b_d1 = TS;
      b_start = 1'b1;
      @(negedge clock);
      b_start = 1'b0;
      for (int cyc = 1; cyc <= 45; cyc++) begin
         if (b_done) begin
            pulses++;
            if (pulses == 1) begin
               first_cyc = cyc;
               ts1       = b_ts_ok;
               b_d1      = 32'h0BAD_F00D;
            end else if (pulses == 2) begin
               second_cyc = cyc;
               ts2        = b_ts_ok;
            end
         end
         if (cyc == 25) busy25 = b_busy;
         if (cyc == 26) busy26 = b_busy;
         @(negedge clock);
      end
      checks++;
      if (pulses !== 2 || first_cyc !== 6 || second_cyc !== 31) begin
         errors++;
         $display("FAIL recheck_done: pulses=%0d at %0d,%0d, want 2 at 6,31", pulses, first_cyc, second_cyc);
      end
      checks++;
      if (ts1 !== 1'b1 || ts2 !== 1'b0 || b_ts_ok !== 1'b0) begin
         errors++;
         $display("FAIL recheck_ts_ok: first=%b second=%b now=%b, want 1 0 0", ts1, ts2, b_ts_ok);
      end
      checks++;
      if (busy25 !== 1'b0 || busy26 !== 1'b1) begin
         errors++;
         $display("FAIL recheck_restart: busy c25=%b c26=%b, want 0 1", busy25, busy26);
      end
      checks++;
      if (b_id_ok !== 1'b1 || b_tmo !== 1'b0 || b_read_ts !== 32'h0BAD_F00D || b_read_id !== 32'h0) begin
         errors++;
         $display("FAIL recheck_data: id_ok=%b tmo=%b id=%h ts=%h, want 1 0 0 0badf00d",
                  b_id_ok, b_tmo, b_read_id, b_read_ts);
      end
   endtask

   initial begin
      test_reset();
      test_match();
      test_id_mismatch();
      test_stall();
      test_timeout();
      test_busy_reset();
      test_recheck();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule
